// File: rtl/clock_pkg.sv
// Shared types for the display scan blocks: scan FSM states and digit-enable polarity.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  localparam logic AN_POL_LOW  = 1'b1;
  localparam logic AN_POL_HIGH = 1'b0;

endpackage

// File: rtl/rr_next_index.sv
// Rotating-priority finder: first set bit of mask searching cur+1, cur+2, ... modulo N.
// Searching all N offsets means cur itself is found last when it is the only set bit.
module rr_next_index #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] cur,
  output logic [W-1:0] next,
  output logic         found
);

  always_comb begin
    int k;
    next  = cur;
    found = 1'b0;
    // Walk from the farthest offset down so the nearest hit is written last.
    for (int i = N; i >= 1; i--) begin
      k = (int'(cur) + i) % N;
      if (mask[k]) begin
        next  = W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/digit_scan_demux.sv
// Time-multiplexed digit scanner: slot prescaler, IDLE/BLANK/DRIVE FSM and registered
// one-hot digit enables with an anti-ghosting blank at the start of every slot.
module digit_scan_demux
  import clock_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SEL_W      = $clog2(DIGITS),
  parameter int DIV        = 100000,
  parameter int BLANK      = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIGITS-1:0] digit_mask,
  output logic [SEL_W-1:0]  sel,
  output logic [DIGITS-1:0] an,
  output logic              blank,
  output logic              scan_tick
);

  localparam int          CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);
  localparam scan_state_e SLOT_START = (BLANK == 0) ? ST_DRIVE : ST_BLANK;
  localparam logic        INV        = (ACTIVE_LOW != 0) ? AN_POL_LOW : AN_POL_HIGH;
  localparam logic [DIGITS-1:0] AN_OFF = INV ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  scan_state_e       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [SEL_W-1:0]  r_sel;
  logic [DIGITS-1:0] r_an;
  logic              r_blank;
  logic              r_tick;

  scan_state_e       w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic              w_tick_nxt;
  logic              w_run;
  logic              w_drive;
  logic [DIGITS-1:0] w_onehot;
  logic [DIGITS-1:0] w_an_nxt;
  logic [SEL_W-1:0]  w_rr_next;
  logic              w_rr_found;
  logic [SEL_W-1:0]  w_rr_idx;

  rr_next_index #(.N(DIGITS), .W(SEL_W)) u_rr (
    .mask  (digit_mask),
    .cur   (r_sel),
    .next  (w_rr_next),
    .found (w_rr_found)
  );

  assign w_rr_idx = w_rr_found ? w_rr_next : r_sel;
  assign w_run    = en && (|digit_mask);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_tick_nxt  = 1'b0;
    if (!w_run) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == ST_IDLE) begin
      w_state_nxt = SLOT_START;
      w_cnt_nxt   = '0;
      w_tick_nxt  = 1'b1;
      w_sel_nxt   = digit_mask[r_sel] ? r_sel : w_rr_idx;
    end else if (r_cnt == LAST) begin
      w_state_nxt = SLOT_START;
      w_cnt_nxt   = '0;
      w_tick_nxt  = 1'b1;
      w_sel_nxt   = w_rr_idx;
    end else begin
      w_cnt_nxt   = r_cnt + 1'b1;
      w_state_nxt = ((int'(r_cnt) + 1) >= BLANK) ? ST_DRIVE : ST_BLANK;
    end
  end

  // Enables are computed from the next state so an/blank line up with state and cnt.
  always_comb begin
    w_drive  = (w_state_nxt == ST_DRIVE) && en && digit_mask[w_sel_nxt];
    w_onehot = w_drive ? (DIGITS'(1) << w_sel_nxt) : '0;
    w_an_nxt = INV ? ~w_onehot : w_onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_an    <= AN_OFF;
      r_blank <= 1'b1;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_an    <= w_an_nxt;
      r_blank <= ~w_drive;
      r_tick  <= w_tick_nxt;
    end
  end

  assign sel       = r_sel;
  assign an        = r_an;
  assign blank     = r_blank;
  assign scan_tick = r_tick;

endmodule

// File: tb/tb_digit_scan_demux.sv
// Bench for digit_scan_demux (DIGITS=4, DIV=8, BLANK=2, active-low) against a slot-position model.
module tb_digit_scan_demux;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] mask = 4'hF;
  logic [1:0] sel;
  logic [3:0] an;
  logic       blank;
  logic       scan_tick;

  int checks = 0;
  int failures = 0;

  // Model: whether scanning, position inside the slot, current digit, tick flag.
  bit m_active = 0;
  int m_pos = 0;
  int m_sel = 0;
  bit m_tick = 0;

  digit_scan_demux #(
    .DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(mask),
    .sel(sel), .an(an), .blank(blank), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  function automatic int next_digit(int cur, logic [3:0] m);
    for (int k = 1; k <= DIGITS; k++)
      if (m[(cur + k) % DIGITS]) return (cur + k) % DIGITS;
    return cur;
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] oh;
    oh = 4'b0001 << m_sel;
    if (m_active && m_pos >= BLANK && en && mask[m_sel]) return ~oh;
    return 4'b1111;
  endfunction

  task automatic model_step();
    if (!(en && mask != 4'b0)) begin
      m_active = 0; m_pos = 0; m_tick = 0;
    end else if (!m_active) begin
      m_active = 1; m_pos = 0; m_tick = 1;
      if (!mask[m_sel]) m_sel = next_digit(m_sel, mask);
    end else if (m_pos == DIV - 1) begin
      m_pos = 0; m_tick = 1; m_sel = next_digit(m_sel, mask);
    end else begin
      m_pos++; m_tick = 0;
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_sel = 0; m_tick = 0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    logic [3:0] ea;
    ea = exp_an();
    chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
    chk({tag, ".an"}, 32'(an), 32'(ea));
    chk({tag, ".blank"}, 32'(blank), 32'(ea == 4'b1111));
    chk({tag, ".tick"}, 32'(scan_tick), 32'(m_tick));
  endtask

  // Inputs are stable here (set at the previous negedge); check at the following negedge.
  task automatic cycle(string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic wait_slot(string tag, int want_sel, int want_pos);
    int budget;
    budget = 64;
    while (!(m_active && m_pos == want_pos && (want_sel < 0 || m_sel == want_sel))
           && budget > 0) begin
      cycle(tag);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $error("FAIL %s.timeout observed=no_slot expected=sel%0d_pos%0d", tag, want_sel, want_pos);
    end
  endtask

  initial begin
    // Reset held across several edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.an", 32'(an), 32'hF);
      chk("rst.sel", 32'(sel), 32'h0);
      chk("rst.blank", 32'(blank), 32'h1);
      chk("rst.tick", 32'(scan_tick), 32'h0);
    end

    rst_n = 1'b1;
    en = 1'b1;
    mask = 4'hF;
    run("full", 40);

    mask = 4'b0101;
    run("alt", 34);

    // Clear current digit's mask bit in slot cycle 4.
    mask = 4'hF;
    wait_slot("mid.align", -1, 4);
    mask[m_sel] = 1'b0;
    run("mid", 12);

    // Drop enable in DRIVE of digit 2, raise 5 cycles later.
    mask = 4'hF;
    wait_slot("en.align", 2, 4);
    en = 1'b0;
    run("en.off", 5);
    en = 1'b1;
    cycle("en.blank0");
    chk("en.blank0.an", 32'(an), 32'hF);
    cycle("en.blank1");
    chk("en.blank1.an", 32'(an), 32'hF);
    cycle("en.drive");
    chk("en.drive.an", 32'(an), 32'b1011);
    chk("en.drive.sel", 32'(sel), 32'd2);
    run("en.resume", 10);

    // Randomized enable and mask traffic.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom_range(0, 15));
      cycle("rand");
    end

    // Asynchronous reset between edges while driving.
    en = 1'b1;
    mask = 4'hF;
    wait_slot("ar.align", -1, 4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar.an", 32'(an), 32'hF);
    chk("ar.blank", 32'(blank), 32'h1);
    chk("ar.sel", 32'(sel), 32'h0);
    chk("ar.tick", 32'(scan_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run("ar.resume", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
